// File: rtl/mux_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_port_arbiter
// Description : Round-robin arbiter for a shared 4:1 mux-selected port.
//               Includes a bounded hold time per owner.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_port_arbiter #(
   parameter int MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       busy
);

   localparam int              CW         = $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0]   c_MAX_HOLD = CW'(MAX_HOLD);
   localparam logic [CW-1:0]   c_CNT_ONE  = CW'(1);
   localparam logic [0:0]      c_IDLE     = 1'b0;
   localparam logic [0:0]      c_OWN      = 1'b1;

   logic [0:0]    r_state;
   logic [3:0]    r_gnt;
   logic [1:0]    r_sel;
   logic [1:0]    r_ptr;
   logic [CW-1:0] r_cnt;

   logic [3:0]    w_others;
   logic          w_owner_req;
   logic [3:0]    w_scan;
   logic          w_found;
   logic [1:0]    w_win;
   logic [1:0]    w_idx;
   logic          w_take;
   logic          w_release;

   // While owning, only the other requesters compete; the owner is masked out.
   always_comb begin
      w_others    = req & ~r_gnt;
      w_owner_req = |(req & r_gnt);
      w_scan      = (r_state == c_OWN) ? w_others : req;
      w_found     = 1'b0;
      w_win       = r_ptr;
      w_idx       = r_ptr;
      for (int k = 0; k < 4; k++) begin
         w_idx = r_ptr + 2'(k);
         if (!w_found && w_scan[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   always_comb begin
      w_take    = 1'b0;
      w_release = 1'b0;
      if (r_state == c_IDLE) begin
         w_take = w_found;
      end else begin
         w_take    = w_found && (!w_owner_req || (r_cnt >= c_MAX_HOLD));
         w_release = !w_owner_req && !w_found;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= c_IDLE;
         r_gnt   <= 4'b0000;
         r_sel   <= 2'b00;
         r_ptr   <= 2'b00;
         r_cnt   <= '0;
      end else if (w_take) begin
         r_state <= c_OWN;
         r_gnt   <= 4'b0001 << w_win;
         r_sel   <= w_win;
         r_ptr   <= w_win + 2'd1;
         r_cnt   <= c_CNT_ONE;
      end else if (w_release) begin
         r_state <= c_IDLE;
         r_gnt   <= 4'b0000;
      end else if ((r_state == c_OWN) && (r_cnt < c_MAX_HOLD)) begin
         r_cnt   <= r_cnt + c_CNT_ONE;
      end
   end

   assign gnt  = r_gnt;
   assign sel  = r_sel;
   assign busy = |r_gnt;

endmodule
`default_nettype wire

// File: tb/tb_mux_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_port_arbiter
// Description : Directed self-checking bench for mux_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_port_arbiter;

   logic       clk;
   logic       reset_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy;

   int vectors;
   int miscompares;

   mux_port_arbiter #(.MAX_HOLD(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .gnt     (gnt),
      .sel     (sel),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs only change after a falling edge, so req is still the value seen at the last rising edge.
   task automatic test_invariants;
      logic [1:0] enc;
      enc = gnt[3] ? 2'd3 : gnt[2] ? 2'd2 : gnt[1] ? 2'd1 : 2'd0;
      vectors++;
      if ($onehot0(gnt) !== 1'b1) begin
         miscompares++;
         $display("FAIL onehot0: gnt=%b", gnt);
      end
      vectors++;
      if (busy !== (|gnt)) begin
         miscompares++;
         $display("FAIL busy_or: busy=%b expected %b (gnt=%b)", busy, |gnt, gnt);
      end
      if (busy === 1'b1) begin
         vectors++;
         if (sel !== enc) begin
            miscompares++;
            $display("FAIL sel_enc: sel=%b expected %b (gnt=%b)", sel, enc, gnt);
         end
      end
      vectors++;
      if ((gnt & ~req) !== 4'b0000) begin
         miscompares++;
         $display("FAIL gnt_without_req: gnt=%b req=%b", gnt, req);
      end
   endtask

   task automatic step;
      @(negedge clk);
      test_invariants();
   endtask

   task automatic expect_out(input string name, input logic [3:0] eg, input logic [1:0] es,
                             input logic eb);
      vectors++;
      if ({gnt, sel, busy} !== {eg, es, eb}) begin
         miscompares++;
         $display("FAIL %s: gnt=%b sel=%b busy=%b expected gnt=%b sel=%b busy=%b",
                  name, gnt, sel, busy, eg, es, eb);
      end
   endtask

   task automatic do_reset(input logic [3:0] r);
      @(negedge clk);
      reset_n = 1'b0;
      req     = r;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      req     = 4'b0000;
      #1;
      expect_out("reset_immediate", 4'b0000, 2'b00, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step();
         expect_out("reset_hold", 4'b0000, 2'b00, 1'b0);
      end
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_out("idle_no_req", 4'b0000, 2'b00, 1'b0);
      end
   endtask

   task automatic test_single;
      req = 4'b0100;
      step();
      expect_out("single_grant", 4'b0100, 2'b10, 1'b1);
      for (int i = 0; i < 20; i++) begin
         step();
         expect_out("single_hold", 4'b0100, 2'b10, 1'b1);
      end
      req = 4'b0000;
      step();
      expect_out("single_drop", 4'b0000, 2'b10, 1'b0);
   endtask

   task automatic test_contention;
      logic [1:0] idx;
      do_reset(4'b1111);
      for (int k = 0; k < 20; k++) begin
         step();
         idx = 2'((k / 4) % 4);
         expect_out("contention_rotate", 4'b0001 << idx, idx, 1'b1);
      end
   endtask

   task automatic test_back_to_back;
      do_reset(4'b0010);
      step();
      expect_out("handoff_setup", 4'b0010, 2'b01, 1'b1);
      req = 4'b1001;
      step();
      vectors++;
      if (gnt === 4'b0000) begin
         miscompares++;
         $display("FAIL handoff_bubble: gnt=%b expected nonzero", gnt);
      end
      expect_out("handoff_target", 4'b1000, 2'b11, 1'b1);
   endtask

   task automatic test_wraparound;
      do_reset(4'b0100);
      step();
      expect_out("wrap_setup", 4'b0100, 2'b10, 1'b1);
      req = 4'b0000;
      step();
      expect_out("wrap_idle", 4'b0000, 2'b10, 1'b0);
      req = 4'b0101;
      step();
      expect_out("wrap_grant", 4'b0001, 2'b00, 1'b1);
   endtask

   task automatic test_mid_reset;
      do_reset(4'b1000);
      step();
      expect_out("midrst_setup", 4'b1000, 2'b11, 1'b1);
      req = 4'b1001;
      step();
      expect_out("midrst_contend", 4'b1000, 2'b11, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      expect_out("midrst_async_clear", 4'b0000, 2'b00, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      req     = 4'b1000;
      step();
      expect_out("midrst_regrant", 4'b1000, 2'b11, 1'b1);
      // Grant 1 leaves ptr at 2; after reset the pointer must be back at 0.
      do_reset(4'b0010);
      step();
      expect_out("ptr_setup", 4'b0010, 2'b01, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      expect_out("ptr_async_clear", 4'b0000, 2'b00, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      req     = 4'b1001;
      step();
      expect_out("ptr_restart", 4'b0001, 2'b00, 1'b1);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_single();
      test_contention();
      test_back_to_back();
      test_wraparound();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
